// File: rtl/dpram_host_port.sv
// rtl/dpram_host_port.sv - auto-incrementing two-register host port onto port B of the shared dual-port RAM
//
// Ports:
//   clock, reset_n       system clock (also RAM port B clock), synchronous active-low reset
//   cpu_sel              register select: 0 = data, 1 = control/status
//   cpu_wr, cpu_rd       single-cycle host strobes (write wins when both are high)
//   cpu_din, cpu_dout    host write data in, registered host read data out
//   busy                 a RAM access is in progress; strobes seen now are dropped
//   ram_addr/ram_data    RAM address_b / data_b
//   ram_wren/ram_rden    RAM wren_b / rden_b
//   ram_q                RAM q_b, valid the cycle after ram_rden

module dpram_host_port #(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_sel,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [7:0]        ram_q
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAPT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_set;
    logic [7:0]        ptr_lo;
    logic [7:0]        buffer;
    logic              toggle;
    logic              overrun;
    logic              do_wr;
    logic              do_rd;

    // Next-state decode and RAM strobes. The strobes come straight from the
    // state register, so a reset drops them at the very next edge.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        ram_rden  = (state == RD_ISSUE);
        ram_wren  = (state == WR_ISSUE);
        do_wr     = cpu_wr;
        do_rd     = cpu_rd & ~cpu_wr;
        ptr_set   = {cpu_din[ADDR_W-9:0], ptr_lo};
        case (state)
            IDLE: begin
                if (do_wr && !cpu_sel)
                    state_nxt = WR_ISSUE;
                else if (do_wr && cpu_sel && toggle && !cpu_din[6])
                    state_nxt = RD_ISSUE;      // read set-up prefetch
                else if (do_rd && !cpu_sel)
                    state_nxt = RD_ISSUE;
            end
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = IDLE;
            WR_ISSUE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            ptr_lo   <= '0;
            buffer   <= '0;
            toggle   <= 1'b0;
            overrun  <= 1'b0;
            cpu_dout <= '0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            state <= state_nxt;

            if (state != IDLE && (cpu_wr || cpu_rd))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (do_wr) begin
                        if (cpu_sel) begin
                            if (!toggle) begin
                                ptr_lo <= cpu_din;
                                toggle <= 1'b1;
                            end else begin
                                toggle <= 1'b0;
                                if (!cpu_din[7])
                                    ptr <= ptr_set;
                                // RAM address is presented from a register so it
                                // holds its last value once the access is over.
                                if (!cpu_din[6])
                                    ram_addr <= cpu_din[7] ? ptr : ptr_set;
                            end
                        end else begin
                            toggle   <= 1'b0;
                            ram_addr <= ptr;
                            ram_data <= cpu_din;
                        end
                    end else if (do_rd) begin
                        toggle <= 1'b0;
                        if (cpu_sel) begin
                            cpu_dout <= {busy, overrun, 6'b0};
                            overrun  <= 1'b0;
                        end else begin
                            // Host gets the read-ahead value now; the refill
                            // of the buffer runs in the background.
                            cpu_dout <= buffer;
                            ram_addr <= ptr;
                        end
                    end
                end
                RD_CAPT: begin
                    buffer <= ram_q;
                    ptr    <= ptr + PTR_ONE;
                end
                WR_ISSUE: begin
                    // Keep the read-ahead coherent with what was just written.
                    buffer <= ram_data;
                    ptr    <= ptr + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_host_port.sv
// tb/tb_dpram_host_port.sv - directed scoreboard bench for dpram_host_port

module tb_dpram_host_port;

    localparam int ADDR_W = 14;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cpu_sel = 1'b0;
    logic              cpu_wr = 1'b0;
    logic              cpu_rd = 1'b0;
    logic [7:0]        cpu_din = 8'h00;
    logic [7:0]        cpu_dout;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_wren;
    logic              ram_rden;
    logic [7:0]        ram_q = 8'h00;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } acc_t;

    acc_t exp_q[$];
    acc_t e;

    int checks = 0;
    int passed = 0;

    dpram_host_port #(.ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cpu_sel  (cpu_sel),
        .cpu_wr   (cpu_wr),
        .cpu_rd   (cpu_rd),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_rden (ram_rden),
        .ram_q    (ram_q)
    );

    always #5 clock = ~clock;

    // RAM port B model: registered read, write on the same edge.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every RAM access cycle must match the next expected access.
    always @(negedge clock) begin
        if (ram_rden || ram_wren) begin
            chk("rden_wren_exclusive", {31'b0, ram_rden & ram_wren}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ram_access", {ram_wren, 7'b0, 10'b0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("ram_kind_wren", {31'b0, ram_wren}, {31'b0, e.wr});
                chk("ram_addr", {18'b0, ram_addr}, {18'b0, e.addr});
                if (e.wr) chk("ram_data", {24'b0, ram_data}, {24'b0, e.data});
            end
        end
    end

    task automatic expect_acc(input logic wr, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        exp_q.push_back({wr, addr, data});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic sel, input logic wr, input logic rd, input logic [7:0] din);
        cpu_sel = sel;
        cpu_wr  = wr;
        cpu_rd  = rd;
        cpu_din = din;
        step();
        cpu_wr  = 1'b0;
        cpu_rd  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        if (busy !== 1'b0) chk({tag, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[14'h1234] = 8'hAB;
        mem[14'h1235] = 8'hCD;

        // Reset
        step();
        step();
        chk("rst_cpu_dout", {24'b0, cpu_dout}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ram_addr", {18'b0, ram_addr}, 32'h0);
        chk("rst_ram_data", {24'b0, ram_data}, 32'h0);
        chk("rst_strobes", {30'b0, ram_wren, ram_rden}, 32'h0);
        reset_n = 1'b1;
        step();

        // Read set-up at 0x1234, prefetch, then two data reads
        strobe(1'b1, 1'b1, 1'b0, 8'h34);
        chk("t1_no_access_first_ctrl", {31'b0, busy}, 32'h0);
        expect_acc(1'b0, 14'h1234, 8'h00);
        strobe(1'b1, 1'b1, 1'b0, 8'h12);
        chk("t1_prefetch_busy", {31'b0, busy}, 32'h1);
        step();
        chk("t1_busy_2nd_cycle", {31'b0, busy}, 32'h1);
        step();
        chk("t1_busy_done", {31'b0, busy}, 32'h0);
        expect_acc(1'b0, 14'h1235, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_read0", {24'b0, cpu_dout}, 32'hAB);
        wait_idle("t1a");
        expect_acc(1'b0, 14'h1236, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_read1", {24'b0, cpu_dout}, 32'hCD);
        wait_idle("t1b");

        // Write set-up at 0x0000, two writes, read returns last written
        strobe(1'b1, 1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b1, 1'b0, 8'h40);
        chk("t2_write_setup_no_access", {31'b0, busy}, 32'h0);
        expect_acc(1'b1, 14'h0000, 8'h11);
        strobe(1'b0, 1'b1, 1'b0, 8'h11);
        chk("t2_write_busy", {31'b0, busy}, 32'h1);
        step();
        chk("t2_write_busy_1cycle", {31'b0, busy}, 32'h0);
        expect_acc(1'b1, 14'h0001, 8'h22);
        strobe(1'b0, 1'b1, 1'b0, 8'h22);
        step();
        expect_acc(1'b0, 14'h0002, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t2_read_after_write", {24'b0, cpu_dout}, 32'h22);
        wait_idle("t2");
        chk("t2_mem0", {24'b0, mem[0]}, 32'h11);
        chk("t2_mem1", {24'b0, mem[1]}, 32'h22);

        // Pointer wrap at 0x3FFF
        strobe(1'b1, 1'b1, 1'b0, 8'hFF);
        strobe(1'b1, 1'b1, 1'b0, 8'h7F);
        expect_acc(1'b1, 14'h3FFF, 8'h55);
        strobe(1'b0, 1'b1, 1'b0, 8'h55);
        step();
        expect_acc(1'b0, 14'h0000, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_read_after_wrap_write", {24'b0, cpu_dout}, 32'h55);
        wait_idle("t3a");
        chk("t3_mem3fff", {24'b0, mem[14'h3FFF]}, 32'h55);
        expect_acc(1'b0, 14'h0001, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_read_wrapped", {24'b0, cpu_dout}, 32'h11);
        wait_idle("t3b");

        // Overrun: write strobe while busy is dropped
        expect_acc(1'b0, 14'h0002, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t4_read", {24'b0, cpu_dout}, 32'h22);
        strobe(1'b0, 1'b1, 1'b0, 8'h99);
        wait_idle("t4");
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        chk("t4_status_overrun", {24'b0, cpu_dout}, 32'h40);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        chk("t4_status_cleared", {24'b0, cpu_dout}, 32'h00);

        // Simultaneous wr+rd on data: only the write happens
        expect_acc(1'b1, 14'h0003, 8'h77);
        strobe(1'b0, 1'b1, 1'b1, 8'h77);
        wait_idle("t5a");
        chk("t5_mem3", {24'b0, mem[3]}, 32'h77);

        // Reset during RD_CAPT
        expect_acc(1'b0, 14'h0004, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t5_read_buffer", {24'b0, cpu_dout}, 32'h77);
        step();
        reset_n = 1'b0;
        step();
        chk("t5_rst_busy", {31'b0, busy}, 32'h0);
        chk("t5_rst_strobes", {30'b0, ram_wren, ram_rden}, 32'h0);
        reset_n = 1'b1;
        step();
        expect_acc(1'b0, 14'h0000, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t5_buffer_cleared", {24'b0, cpu_dout}, 32'h00);
        wait_idle("t5b");

        // Control read between control writes clears the toggle
        strobe(1'b1, 1'b1, 1'b0, 8'h34);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        chk("t6_status", {24'b0, cpu_dout}, 32'h00);
        strobe(1'b1, 1'b1, 1'b0, 8'h56);
        chk("t6_no_access_low_byte", {31'b0, busy}, 32'h0);
        expect_acc(1'b0, 14'h0156, 8'h00);
        strobe(1'b1, 1'b1, 1'b0, 8'h01);
        wait_idle("t6");
        step();
        step();

        chk("all_expected_accesses_seen", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dpram_host_port.md
Name: dpram_host_port

Overview:
- Auto-incrementing host (CPU) access port that drives port B of the shared dual-port video/buffer RAM. Port A stays with the display/engine side.
- Presents a 2-register, TMS9918-style interface: a control register for the address set-up sequence and status, and a data register for reads and writes.
- Sequences the RAM's 1-cycle registered read with a read-ahead buffer, so host data reads return immediately.

Parameters:
- ADDR_W, 14, RAM address width; legal range 9..14. Data width is fixed at 8.

Ports:
- clock  in  1  system clock; the RAM port B clock is the same net.
- reset_n  in  1  synchronous, active-low reset.
- cpu_sel  in  1  register select: 0 = data, 1 = control/status.
- cpu_wr  in  1  single-cycle write strobe.
- cpu_rd  in  1  single-cycle read strobe.
- cpu_din  in  8  host write data.
- cpu_dout  out  8  registered host read data.
- busy  out  1  RAM access in progress.
- ram_addr  out  ADDR_W  to RAM address_b.
- ram_data  out  8  to RAM data_b.
- ram_wren  out  1  to RAM wren_b.
- ram_rden  out  1  to RAM rden_b.
- ram_q  in  8  from RAM q_b; valid the cycle after ram_rden.

Behaviour:
- Reset: all outputs 0; pointer, read-ahead buffer, toggle and overrun cleared; state IDLE. Reset mid-access aborts it; ram_wren/ram_rden are 0 from the next edge.
- State machine states: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE. busy=1 in every state except IDLE.
- Strobe arbitration: strobes are sampled only in IDLE. If cpu_wr and cpu_rd are both high, the write wins. A strobe arriving while busy=1 is dropped and sets the sticky overrun flag.
- Control write, first (toggle=0): latch ptr_lo <= cpu_din; toggle <= 1. No RAM access.
- Control write, second (toggle=1): toggle <= 0.
  - If cpu_din[7]=1: reserved; the pointer is unchanged.
  - Otherwise: ptr <= {cpu_din[ADDR_W-9:0], ptr_lo}.
  - If cpu_din[6]=0 (read set-up): go to RD_ISSUE (prefetch).
  - If cpu_din[6]=1 (write set-up): no access.
- Control read: cpu_dout <= {busy, overrun, 6'b0} at the next edge, then overrun <= 0 and toggle <= 0.
- Data read, strobe at edge E0:
  - cpu_dout <= buffer at E0; the host sees it the cycle after the strobe.
  - toggle <= 0; go to RD_ISSUE.
- RD_ISSUE (the cycle after E0): ram_rden=1, ram_addr=ptr. Go to RD_CAPT.
- RD_CAPT: at the next edge, buffer <= ram_q, ptr <= ptr+1, state <= IDLE.
  - busy is high for exactly 2 cycles per read or prefetch.
- Data write, strobe at E0:
  - toggle <= 0; go to WR_ISSUE.
  - WR_ISSUE: ram_wren=1, ram_addr=ptr, ram_data=din captured at E0.
  - At the next edge: buffer <= captured din, ptr <= ptr+1, state <= IDLE. busy is high for 1 cycle.
- ram_rden and ram_wren are never high together. Both are 0 in IDLE; ram_addr and ram_data hold their last values.
- Pointer arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 increments to 0.
- A data access between the two control writes clears toggle, so the next control write is treated as a first write.

Test Plan:
- Reset, then ctrl writes 0x34, 0x12 (ADDR_W=14, RAM[0x1234]=0xAB, RAM[0x1235]=0xCD) -> ram_rden pulses 1 cycle at addr 0x1234. Then a data read returns 0xAB and a second read returns 0xCD; the pointer ends at 0x1236.
- Ctrl writes 0x00, 0x40, then data writes 0x11, 0x22 spaced 2 cycles apart -> ram_wren pulses at addr 0x0000 then 0x0001 with data 0x11 and 0x22. A following data read returns 0x22 (read-ahead updated by the write).
- Ctrl writes 0xFF, 0x7F, then a data write 0x55 followed by a data read -> write lands at 0x3FFF; the pointer wraps to 0x0000; the read prefetches from 0x0000.
- Data read strobe, then a write strobe on the very next cycle (busy=1) -> write dropped, no ram_wren. A control read returns 0xC0 or 0x40 (overrun set); a second control read returns overrun=0.
- cpu_wr and cpu_rd asserted together on the data register -> only the write is performed and no RAM read is issued. Separately, reset_n low during RD_CAPT -> buffer stays 0, ptr 0, busy 0 after the edge.
- Ctrl write 0x34, then a control read, then ctrl write 0x56 -> 0x56 is treated as the low byte (toggle was cleared) and no RAM access occurs.
